// File: rtl/motor_pwm_controller.sv
// Four-channel ESC pulse generator with OFF/ARM/RUN/IDLE sequencing on a fixed frame.
// Build option: define MOTOR_SLEW_LIMIT_EN to rate-limit each throttle by SLEW_STEP per frame.
module motor_pwm_controller #(
  parameter int CLK_FRQ_MHZ = 50,
  parameter int FRAME_US    = 20000,
  parameter int ARM_FRAMES  = 100,
  parameter int SLEW_STEP   = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       idle,
  input  logic       soft_reset,
  input  logic [7:0] throttle1,
  input  logic [7:0] throttle2,
  input  logic [7:0] throttle3,
  input  logic [7:0] throttle4,
  output logic       pwm1,
  output logic       pwm2,
  output logic       pwm3,
  output logic       pwm4,
  output logic       armed,
  output logic       frame_start
);

  localparam int PW = (CLK_FRQ_MHZ > 1) ? $clog2(CLK_FRQ_MHZ) : 1;
  localparam int UW = $clog2(FRAME_US);
  localparam int FW = (ARM_FRAMES > 1) ? $clog2(ARM_FRAMES) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_FRQ_MHZ - 1);
  localparam logic [UW-1:0] US_MAX    = UW'(FRAME_US - 1);
  localparam logic [FW-1:0] ARM_LAST  = FW'(ARM_FRAMES - 1);
  localparam logic [10:0]   MIN_WIDTH = 11'd1000;

`ifdef MOTOR_SLEW_LIMIT_EN
  localparam int STEP_LIM = SLEW_STEP;
`else
  // A step of at least full scale always reaches the target in one frame: a direct load.
  localparam int STEP_LIM = (SLEW_STEP > 255) ? SLEW_STEP : 255;
`endif

  typedef enum logic [1:0] {S_OFF, S_ARM, S_RUN, S_IDLE} state_t;

  state_t          state, state_nx;
  logic [1:0]      rst_sync;
  logic            rst_n;
  logic [PW-1:0]   presc;
  logic [UW-1:0]   us_cnt;
  logic [FW-1:0]   frm_cnt;
  logic            req_q;
  logic            tick, frame_end;
  logic [7:0]      thr [4];
  logic [7:0]      t_q [4];
  logic [10:0]     width [4];
  logic [3:0]      pwm_v;

  assign thr[0] = throttle1;
  assign thr[1] = throttle2;
  assign thr[2] = throttle3;
  assign thr[3] = throttle4;

  function automatic logic [7:0] t_step(input logic [7:0] cur, input logic [7:0] tgt);
    int diff;
    diff = int'(tgt) - int'(cur);
    if (diff > STEP_LIM)  return cur + 8'(STEP_LIM);
    if (diff < -STEP_LIM) return cur - 8'(STEP_LIM);
    return tgt;
  endfunction

  // Reset asserts asynchronously but releases two clocks after the pin deasserts.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  assign tick      = (state != S_OFF) && (presc == PRESC_MAX);
  assign frame_end = tick && (us_cnt == US_MAX);

  // NOTE: clocked state uses non-blocking '<=' so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state <= S_OFF;
    else        state <= state_nx;
  end

  // NOTE: combinational blocks assign a default first so no path infers a latch.
  always_comb begin
    state_nx = state;
    if (soft_reset) state_nx = S_OFF;
    else begin
      unique case (state)
        S_OFF:  if (start) state_nx = S_ARM;
        S_ARM:  if (frame_end && frm_cnt == ARM_LAST) state_nx = S_RUN;
        S_RUN:  if (frame_end && (req_q || idle)) state_nx = S_IDLE;
        S_IDLE: if (frame_end && !idle && (req_q || start)) state_nx = S_RUN;
      endcase
    end
  end

  always_comb begin
    armed = (state == S_RUN) || (state == S_IDLE);
    for (int i = 0; i < 4; i++) begin
      width[i] = (state == S_RUN) ? MIN_WIDTH + 11'({t_q[i], 2'b00}) : MIN_WIDTH;
      pwm_v[i] = (state != S_OFF) && (32'(us_cnt) < 32'(width[i]));
    end
  end

  assign {pwm4, pwm3, pwm2, pwm1} = pwm_v;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      presc       <= '0;
      us_cnt      <= '0;
      frm_cnt     <= '0;
      req_q       <= 1'b0;
      frame_start <= 1'b0;
    end else if (soft_reset || state == S_OFF) begin
      presc       <= '0;
      us_cnt      <= '0;
      frm_cnt     <= '0;
      req_q       <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      presc       <= tick ? '0 : presc + 1'b1;
      frame_start <= frame_end;
      if (tick) us_cnt <= (us_cnt == US_MAX) ? '0 : us_cnt + 1'b1;
      if (state == S_ARM && frame_end) frm_cnt <= frm_cnt + 1'b1;
      // A mode request seen anywhere in the frame is held until the boundary applies it.
      if (frame_end || state == S_ARM)      req_q <= 1'b0;
      else if (state == S_RUN && idle)      req_q <= 1'b1;
      else if (state == S_IDLE)             req_q <= !idle && (req_q || start);
    end
  end

  // NOTE: t_q is four small registers rather than a RAM, so resetting it costs nothing.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) t_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (soft_reset || state == S_OFF) t_q[i] <= '0;
        else if (frame_end)               t_q[i] <= (state_nx == S_RUN) ? t_step(t_q[i], thr[i]) : '0;
      end
    end
  end

endmodule

// File: tb/tb_motor_pwm_controller.sv
// Scoreboard bench: stimulus pushes per-frame expected pulse widths, a monitor measures each frame.
// Short frames (2 MHz, 2048 us) keep the run small; MOTOR_SLEW_LIMIT_EN switches the model too.
module tb_motor_pwm_controller;

  localparam int CLK_MHZ   = 2;
  localparam int FRAME     = 2048;
  localparam int ARMF      = 2;
  localparam int STEP      = 8;
  localparam int FRAME_CYC = CLK_MHZ * FRAME;

  logic       clock = 1'b0;
  logic       reset, start, idle, soft_reset;
  logic [7:0] thr_drv [4];
  logic [3:0] pwm;
  logic       armed, frame_start;

  typedef struct {
    int w [4];
  } frame_exp_t;

  frame_exp_t exp_q [$];
  frame_exp_t mon_e;
  int         n_tests = 0;
  int         n_fail  = 0;
  int         t_model [4];
  int         hi_cnt [4];
  int         frame_no = 0;
  bit         mon_en = 1'b0;

  motor_pwm_controller #(
    .CLK_FRQ_MHZ(CLK_MHZ), .FRAME_US(FRAME), .ARM_FRAMES(ARMF), .SLEW_STEP(STEP)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .idle(idle), .soft_reset(soft_reset),
    .throttle1(thr_drv[0]), .throttle2(thr_drv[1]), .throttle3(thr_drv[2]), .throttle4(thr_drv[3]),
    .pwm1(pwm[0]), .pwm2(pwm[1]), .pwm3(pwm[2]), .pwm4(pwm[3]),
    .armed(armed), .frame_start(frame_start)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference throttle tracking: jump to target, or approach it by at most STEP when slewed.
  function automatic int model_t(input int cur, input int tgt);
`ifdef MOTOR_SLEW_LIMIT_EN
    if (tgt > cur + STEP) return cur + STEP;
    if (tgt < cur - STEP) return cur - STEP;
`endif
    return tgt;
  endfunction

  task automatic set_thr(input int a, input int b, input int c, input int d);
    thr_drv[0] = 8'(a); thr_drv[1] = 8'(b); thr_drv[2] = 8'(c); thr_drv[3] = 8'(d);
  endtask

  task automatic set_thr_rand();
    set_thr($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
  endtask

  // Next frame is a RUN frame using the throttles present at its starting boundary.
  task automatic push_run();
    frame_exp_t e;
    for (int i = 0; i < 4; i++) begin
      t_model[i] = model_t(t_model[i], int'(thr_drv[i]));
      e.w[i] = 1000 + 4 * t_model[i];
    end
    exp_q.push_back(e);
  endtask

  // Next frame is an ARM or IDLE frame: minimum pulse, latched throttles zero.
  task automatic push_min();
    frame_exp_t e;
    for (int i = 0; i < 4; i++) begin
      t_model[i] = 0;
      e.w[i] = 1000;
    end
    exp_q.push_back(e);
  endtask

  task automatic wait_frame();
    bit seen = 1'b0;
    for (int c = 0; c < FRAME_CYC + 16 && !seen; c++) begin
      @(negedge clock);
      if (frame_start) seen = 1'b1;
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL frame_wait: no frame_start within %0d cycles", FRAME_CYC + 16);
    end
  endtask

  task automatic wait_rand(input int lo, input int hi);
    repeat ($urandom_range(lo, hi)) @(negedge clock);
  endtask

  // Monitor: a frame_start closes the previous frame; its per-channel high time is scored.
  always @(negedge clock) begin
    if (!mon_en) begin
      for (int i = 0; i < 4; i++) hi_cnt[i] = 0;
    end else if (frame_start) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL frame_unexpected: frame %0d ended with nothing expected", frame_no);
      end else begin
        mon_e = exp_q.pop_front();
        for (int i = 0; i < 4; i++)
          check($sformatf("frame%0d_pwm%0d_cycles", frame_no, i + 1), hi_cnt[i], mon_e.w[i] * CLK_MHZ);
      end
      frame_no++;
      for (int i = 0; i < 4; i++) hi_cnt[i] = int'(pwm[i]);
    end else begin
      for (int i = 0; i < 4; i++) hi_cnt[i] += int'(pwm[i]);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit       fs_seen;
    bit       armed_seen;
    logic [3:0] pwm_seen;

    reset = 1'b0; start = 1'b0; idle = 1'b0; soft_reset = 1'b0;
    set_thr(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) t_model[i] = 0;
    repeat (3) @(negedge clock);
    check("reset_pwm", pwm, 0);
    check("reset_armed", armed, 0);
    check("reset_frame_start", frame_start, 0);
    reset = 1'b1;

    // OFF with quiet inputs for over a frame: nothing may move.
    fs_seen = 1'b0; armed_seen = 1'b0; pwm_seen = '0;
    repeat (FRAME_CYC + 8) begin
      @(negedge clock);
      fs_seen |= frame_start; armed_seen |= armed; pwm_seen |= pwm;
    end
    check("off_pwm", pwm_seen, 0);
    check("off_armed", armed_seen, 0);
    check("off_frame_start", fs_seen, 0);

    // Arm: two minimum-pulse frames, a stray start in between, then RUN.
    mon_en = 1'b1;
    push_min();
    push_min();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_frame();
    check("arm_armed_low", armed, 0);
    wait_rand(10, 1500);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_rand(10, 1500);
    set_thr(128, 255, 0, $urandom_range(0, 255));
    push_run();
    wait_frame();
    check("run_armed_high", armed, 1);

    // RUN frames with throttles changed at random points, often mid-pulse.
    repeat (2) begin
      wait_rand(10, FRAME_CYC - 50);
      set_thr_rand();
      push_run();
      wait_frame();
    end

    // start and idle together: idle wins, next frame is minimum width.
    wait_rand(10, FRAME_CYC - 50);
    start = 1'b1;
    idle  = 1'b1;
    push_min();
    wait_frame();
    check("idle_armed_high", armed, 1);
    wait_rand(10, FRAME_CYC - 50);
    idle = 1'b0;
    set_thr_rand();
    push_run();
    wait_frame();
    start = 1'b0;

    // Back to IDLE, then restart with a step to 40 (shows slewing when compiled in).
    wait_rand(10, FRAME_CYC - 50);
    idle = 1'b1;
    push_min();
    wait_frame();
    idle = 1'b0;
    wait_rand(10, FRAME_CYC - 50);
    set_thr(40, 40, 40, 40);
    start = 1'b1;
    push_run();
    wait_frame();
    start = 1'b0;
    repeat (5) begin
      push_run();
      wait_frame();
    end
    wait_frame();
    @(negedge clock);
    mon_en = 1'b0;
    check("scoreboard_drained", exp_q.size(), 0);

    // soft_reset mid-pulse, with start and idle also asserted, wins on the next edge.
    repeat (50) @(negedge clock);
    check("pre_soft_pwm", pwm, 4'hf);
    start = 1'b1; idle = 1'b1; soft_reset = 1'b1;
    @(posedge clock);
    #1;
    check("soft_reset_pwm", pwm, 0);
    check("soft_reset_armed", armed, 0);
    @(negedge clock);
    start = 1'b0; idle = 1'b0; soft_reset = 1'b0;
    fs_seen = 1'b0; armed_seen = 1'b0; pwm_seen = '0;
    repeat (2500) begin
      @(negedge clock);
      fs_seen |= frame_start; armed_seen |= armed; pwm_seen |= pwm;
    end
    check("soft_off_pwm", pwm_seen, 0);
    check("soft_off_frame_start", fs_seen, 0);
    check("soft_off_armed", armed_seen, 0);

    // Asynchronous reset in the middle of an ARM pulse clears outputs without a clock edge.
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (100) @(negedge clock);
    check("pre_reset_pwm", pwm, 4'hf);
    #3;
    reset = 1'b0;
    #1;
    check("async_reset_pwm", pwm, 0);
    check("async_reset_armed", armed, 0);
    check("async_reset_frame_start", frame_start, 0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (5) @(negedge clock);
    check("post_reset_pwm", pwm, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
